// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SPI master SCLK, chip-select and shift/sample strobe timing for all CPOL/CPHA modes
// Define SPI_SCLK_GAP_EN to add cfg_gap and a CS-high GAP state between LAG and DONE.
module spi_sclk_engine #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 5,
    parameter int NCS = 4,
    localparam int CS_W = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             fclk,
    input  logic             preset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CS_W-1:0]  cfg_cs,
`ifdef SPI_SCLK_GAP_EN
    input  logic [7:0]       cfg_gap,
`endif
    input  logic             done_ack,
    output logic             sclk,
    output logic [NCS-1:0]   cs_n,
    output logic             shift_stb,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic [LEN_W:0]   bit_cnt
);
    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        LAG,
`ifdef SPI_SCLK_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t state, state_nx;
    logic cpol_q, cpha_q;
    logic [DIV_W-1:0] div_q, cnt;
    logic [LEN_W-1:0] len_q;
    logic [CS_W-1:0] cs_q;
    logic [LEN_W+1:0] edge_k, edge_nx, two_n;
    logic accept, hp_end, tick, odd, last_edge, cs_act;
`ifdef SPI_SCLK_GAP_EN
    logic [7:0] gap_q, gap_cnt;
`endif

    assign accept = state == IDLE && start && !abort;
    assign hp_end = cnt == div_q;
    assign edge_nx = edge_k + (LEN_W+2)'(1);
    assign two_n = {1'b0, len_q, 1'b1} + (LEN_W+2)'(1);
    assign odd = edge_nx[0];
    assign last_edge = edge_nx == two_n;
    assign tick = (state == LEAD || state == XFER) && hp_end && !abort;
    assign cs_act = state == LEAD || state == XFER || state == LAG;
    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = accept ? LEAD : IDLE;
            LEAD: state_nx = hp_end ? XFER : LEAD;
            XFER: state_nx = (hp_end && last_edge) ? LAG : XFER;
`ifdef SPI_SCLK_GAP_EN
            LAG:  state_nx = hp_end ? GAP : LAG;
            GAP:  state_nx = (gap_cnt == gap_q) ? DONE : GAP;
`else
            LAG:  state_nx = hp_end ? DONE : LAG;
`endif
            DONE: state_nx = done_ack ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NCS; i++)
            cs_n[i] = !(cs_act && cs_q == CS_W'(i));
    end

    always_ff @(posedge fclk or negedge preset_n)
        if (!preset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge fclk or negedge preset_n) begin
        if (!preset_n) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            len_q      <= '0;
            cs_q       <= '0;
            cnt        <= '0;
            edge_k     <= '0;
            sclk       <= 1'b0;
            shift_stb  <= 1'b0;
            sample_stb <= 1'b0;
            bit_cnt    <= '0;
`ifdef SPI_SCLK_GAP_EN
            gap_q      <= '0;
            gap_cnt    <= '0;
`endif
        end else begin
            shift_stb  <= 1'b0;
            sample_stb <= 1'b0;
            cnt <= (cs_act && state_nx == state && !hp_end) ? cnt + DIV_W'(1) : '0;
            if (state == IDLE || state_nx == IDLE)
                sclk <= cfg_cpol;
            if (accept) begin
                cpol_q    <= cfg_cpol;
                cpha_q    <= cfg_cpha;
                div_q     <= cfg_div;
                len_q     <= cfg_len;
                cs_q      <= cfg_cs;
                edge_k    <= '0;
                bit_cnt   <= '0;
                shift_stb <= !cfg_cpha;
`ifdef SPI_SCLK_GAP_EN
                gap_q     <= cfg_gap;
`endif
            end
            // odd edges lead; CPHA picks which edge samples, the other shifts (no shift after the final edge)
            if (tick) begin
                sclk       <= ~sclk;
                edge_k     <= edge_nx;
                sample_stb <= cpha_q ^ odd;
                shift_stb  <= cpha_q ? odd : (!odd && !last_edge);
                if (cpha_q ^ odd)
                    bit_cnt <= bit_cnt + (LEN_W+1)'(1);
            end
`ifdef SPI_SCLK_GAP_EN
            gap_cnt <= (state == GAP && state_nx == GAP) ? gap_cnt + 8'd1 : 8'd0;
`endif
        end
    end
endmodule
